// File: rtl/ddr3_cmd_sequencer.sv
// DDR3 command/address sequencer: expands handshaked commands into two-half PHY
// buses, inserts programmable NOP gaps, keeps sticky CKE/ODT and drives tristate.
module ddr3_cmd_sequencer #(
   parameter int ADDRESS_NUMBER = 15,
   parameter int NOP_WIDTH      = 8,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                        clk_div,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [ADDRESS_NUMBER-1:0]   cmd_addr,
   input  logic [2:0]                  cmd_bank,
   input  logic [2:0]                  cmd_rcw,
   input  logic                        cmd_cke,
   input  logic                        cmd_odt,
   input  logic                        cmd_slot,
   input  logic [NOP_WIDTH-1:0]        cmd_nop,
   output logic [2*ADDRESS_NUMBER-1:0] out_a,
   output logic [5:0]                  out_ba,
   output logic [1:0]                  out_ras,
   output logic [1:0]                  out_cas,
   output logic [1:0]                  out_we,
   output logic [1:0]                  out_cke,
   output logic [1:0]                  out_odt,
   output logic                        out_tri,
   output logic                        busy,
   output logic [CNT_WIDTH-1:0]        cmd_count
);

   logic [NOP_WIDTH-1:0]        cnt;
   logic                        accept;
   logic [2*ADDRESS_NUMBER-1:0] a_pair;
   logic [5:0]                  ba_pair;

   // Gated by rst so no command can be handshaked while the block is held in reset.
   assign cmd_ready = en & (cnt == '0) & ~rst;
   assign accept    = cmd_valid & cmd_ready;
   assign busy      = (cnt != '0);

   always_comb begin
      a_pair  = '0;
      ba_pair = '0;
      for (int unsigned i = 0; i < ADDRESS_NUMBER; i++)
         a_pair[2*i +: 2] = {2{cmd_addr[i]}};
      for (int unsigned i = 0; i < 3; i++)
         ba_pair[2*i +: 2] = {2{cmd_bank[i]}};
   end

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         out_a     <= '0;
         out_ba    <= '0;
         out_ras   <= 2'b11;
         out_cas   <= 2'b11;
         out_we    <= 2'b11;
         out_cke   <= 2'b00;
         out_odt   <= 2'b00;
         out_tri   <= 1'b1;
         cnt       <= '0;
         cmd_count <= '0;
      end else begin
         out_ras <= 2'b11;
         out_cas <= 2'b11;
         out_we  <= 2'b11;
         if (accept) begin
            out_a   <= a_pair;
            out_ba  <= ba_pair;
            out_cke <= {2{cmd_cke}};
            out_odt <= {2{cmd_odt}};
            cnt     <= cmd_nop;
            // Pin levels go into the selected half; the other half idles at NOP.
            if (cmd_slot) begin
               out_ras <= {cmd_rcw[2], 1'b1};
               out_cas <= {cmd_rcw[1], 1'b1};
               out_we  <= {cmd_rcw[0], 1'b1};
            end else begin
               out_ras <= {1'b1, cmd_rcw[2]};
               out_cas <= {1'b1, cmd_rcw[1]};
               out_we  <= {1'b1, cmd_rcw[0]};
            end
            if (cmd_rcw != 3'b111)
               cmd_count <= cmd_count + CNT_WIDTH'(1);
         end else if (cnt != '0) begin
            cnt <= cnt - NOP_WIDTH'(1);
         end
         if (en)
            out_tri <= 1'b0;
         else if (cnt == '0)
            out_tri <= 1'b1;
      end
   end

endmodule
